// File: rtl/xmem_engine.sv
// Byte-serial load/store engine: up to MAX_BYTES per request over an 8-bit memory
// port, addressed through a small file of post-increment / pre-decrement registers.
module xmem_engine #(
    parameter  int ADDR_W    = 15,
    parameter  int RA_W      = 16,
    parameter  int NUM_RA    = 4,
    parameter  int MAX_BYTES = 4,
    localparam int DATA_W    = 8 * MAX_BYTES,
    localparam int SEL_W     = $clog2(NUM_RA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [SEL_W-1:0]  req_ra,
    input  logic              req_am,
    input  logic              req_dir,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              ra_wr_en,
    input  logic [SEL_W-1:0]  ra_wr_sel,
    input  logic [RA_W-1:0]   ra_wr_data,
    input  logic [SEL_W-1:0]  ra_rd_sel,
    output logic [RA_W-1:0]   ra_rd_data,
    output logic              mem_enable_read,
    output logic              mem_enable_write,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_out,
    input  logic [7:0]        mem_data_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] MAX_NB = 3'(MAX_BYTES);

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0, 2'd1: size_bytes = 3'd1;
            2'd2:       size_bytes = 3'd2;
            2'd3:       size_bytes = 3'd4;
            default:    size_bytes = 3'd1;
        endcase
    endfunction

    // UL transfers carry only the low nibble of the selected byte.
    function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] data,
                                             input logic [2:0] k, input logic ul);
        logic [DATA_W-1:0] sh;
        sh = data >> {k, 3'b000};
        if (ul) pick_byte = {4'h0, sh[3:0]};
        else    pick_byte = sh[7:0];
    endfunction

    state_t              r_state, w_state_nxt;
    logic                r_ready, r_write, r_ul, r_am, r_dir;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_wdata, r_acc, r_rdata;
    logic [RA_W-1:0]     r_base;
    logic [2:0]          r_nbytes, r_k;
    logic [RA_W-1:0]     r_ra [NUM_RA];
    logic                r_rd_en, r_wr_en, r_rsp_valid, r_rsp_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_dout;

    logic [2:0]          w_req_nb, w_k_nxt;
    logic                w_req_err, w_accept, w_last, w_in_idle, w_issue;
    logic                w_write_src, w_ul_src, w_ra_upd;
    logic [RA_W-1:0]     w_ra_cur, w_req_base, w_base_src, w_ra_new;
    logic [DATA_W-1:0]   w_wdata_src, w_acc_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [7:0]          w_rbyte;

    assign w_req_nb    = size_bytes(req_size);
    assign w_req_err   = (w_req_nb > MAX_NB);
    assign w_ra_cur    = r_ra[req_ra];
    assign w_req_base  = (req_dir && req_am) ? (w_ra_cur - RA_W'(w_req_nb)) : w_ra_cur;
    assign w_accept    = req_valid && r_ready && (r_state == ST_IDLE);
    assign w_last      = (r_k == (r_nbytes - 3'd1));
    assign w_in_idle   = (r_state == ST_IDLE);

    // The next byte comes from the request itself on accept, else from the latched copy.
    assign w_k_nxt     = w_in_idle ? 3'd0 : (r_k + 3'd1);
    assign w_base_src  = w_in_idle ? w_req_base : r_base;
    assign w_wdata_src = w_in_idle ? req_wdata : r_wdata;
    assign w_write_src = w_in_idle ? req_write : r_write;
    assign w_ul_src    = w_in_idle ? (req_size == 2'd0) : r_ul;
    assign w_issue     = (w_state_nxt == ST_XFER);
    assign w_addr_nxt  = ADDR_W'(w_base_src + RA_W'(w_k_nxt));

    assign w_rbyte     = r_ul ? {4'h0, mem_data_in[3:0]} : mem_data_in;
    assign w_acc_nxt   = r_acc | (DATA_W'(w_rbyte) << {r_k, 3'b000});
    assign w_ra_upd    = (r_state == ST_XFER) && w_last && r_am;
    assign w_ra_new    = r_dir ? r_base : (r_base + RA_W'(r_nbytes));

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_req_err ? ST_DONE : ST_XFER;
                else          w_state_nxt = ST_IDLE;
            end
            ST_XFER: begin
                if (w_last) w_state_nxt = ST_DONE;
                else        w_state_nxt = ST_XFER;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Request latch, load assembly and registered memory/response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready     <= 1'b0;
            r_write     <= 1'b0;
            r_ul        <= 1'b0;
            r_am        <= 1'b0;
            r_dir       <= 1'b0;
            r_sel       <= '0;
            r_wdata     <= '0;
            r_base      <= '0;
            r_nbytes    <= 3'd0;
            r_k         <= 3'd0;
            r_acc       <= '0;
            r_rdata     <= '0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_dout      <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_rd_en     <= w_issue && !w_write_src;
            r_wr_en     <= w_issue && w_write_src;
            r_addr      <= w_issue ? w_addr_nxt : '0;
            r_dout      <= w_issue ? pick_byte(w_wdata_src, w_k_nxt, w_ul_src) : 8'h00;
            r_k         <= w_issue ? w_k_nxt : 3'd0;
            r_rsp_valid <= (w_state_nxt == ST_DONE);
            r_rsp_err   <= w_accept && w_req_err;
            if (w_accept) begin
                r_write  <= req_write;
                r_ul     <= (req_size == 2'd0);
                r_am     <= req_am;
                r_dir    <= req_dir;
                r_sel    <= req_ra;
                r_wdata  <= req_wdata;
                r_base   <= w_req_base;
                r_nbytes <= w_req_nb;
                r_acc    <= '0;
            end else if (r_state == ST_XFER) begin
                r_acc <= w_acc_nxt;
            end
            if ((r_state == ST_XFER) && w_last && !r_write) r_rdata <= w_acc_nxt;
        end
    end

    // Address registers; a direct write lands after the modify so it wins a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RA; i++) r_ra[i] <= '0;
        end else begin
            if (w_ra_upd) r_ra[r_sel] <= w_ra_new;
            if (ra_wr_en) r_ra[ra_wr_sel] <= ra_wr_data;
        end
    end

    assign req_ready        = r_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_err          = r_rsp_err;
    assign rsp_rdata        = r_rdata;
    assign ra_rd_data       = r_ra[ra_rd_sel];
    assign mem_enable_read  = r_rd_en;
    assign mem_enable_write = r_wr_en;
    assign mem_rw           = r_wr_en;
    assign mem_addr         = r_addr;
    assign mem_data_out     = r_dout;

endmodule

// File: doc/xmem_engine.md
XMEM_ENGINE -- requirements
Module: xmem_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, memory address width.
REQ-002 SHALL have parameter RA_W, default 16, address-register width (RA_W >= ADDR_W).
REQ-003 SHALL have parameter NUM_RA, default 4, number of address registers (>= 2).
REQ-004 SHALL have parameter MAX_BYTES, default 4, largest transfer in bytes (1, 2 or 4); DATA_W = 8*MAX_BYTES.
REQ-005 SHALL have ports:
 clk  input  1  sole clock, rising edge.
 rst  input  1  reset; synchronous, active-low (0 = reset).
 req_valid  input  1  access request.
 req_ready  output  1  engine idle, request accepted on clk edge when req_valid & req_ready.
 req_write  input  1  1 = store, 0 = load.
 req_size  input  2  0 = UL nibble, 1 = byte, 2 = word (2 B), 3 = dword (4 B).
 req_ra  input  clog2(NUM_RA)  address register select.
 req_am  input  1  address modify enable.
 req_dir  input  1  0 = post-increment, 1 = pre-decrement.
 req_wdata  input  DATA_W  store data.
 rsp_valid  output  1  one-cycle completion pulse.
 rsp_err  output  1  size error, qualified by rsp_valid.
 rsp_rdata  output  DATA_W  load result, zero-extended, held until next rsp_valid.
 ra_wr_en  input  1  direct RA write.
 ra_wr_sel  input  clog2(NUM_RA)  RA write select.
 ra_wr_data  input  RA_W  RA write value.
 ra_rd_sel  input  clog2(NUM_RA)  RA read select.
 ra_rd_data  output  RA_W  combinational RA[ra_rd_sel].
 mem_enable_read  output  1  byte read strobe; mem_data_in valid same cycle.
 mem_enable_write  output  1  byte write strobe; memory writes on clk edge.
 mem_rw  output  1  1 during write byte, else 0.
 mem_addr  output  ADDR_W  byte address.
 mem_data_out  output  8  write byte.
 mem_data_in  input  8  read byte (combinational).

Function
REQ-006 SHALL implement FSM IDLE -> XFER -> DONE -> IDLE; req_ready = 1 only in IDLE.
REQ-007 On accept, SHALL latch write, size, ra, am, dir, wdata, and base address: RA[ra] - B if dir & am, else RA[ra]; B = 1 for sizes 0/1, 2 for size 2, 4 for size 3.
REQ-008 XFER SHALL issue exactly one byte per cycle for k = 0..B-1, mem_addr = (base + k) mod 2^RA_W truncated to ADDR_W; little-endian (byte k = data[8k+7:8k]).
REQ-009 Read enable and write enable SHALL never be asserted together; both 0 outside XFER.
REQ-010 UL store SHALL write {4'h0, wdata[3:0]}; UL load SHALL return {0, mem_data_in[3:0]}.
REQ-011 Load SHALL capture each mem_data_in byte on the edge ending its XFER cycle; rsp_rdata updates at DONE entry.
REQ-012 DONE SHALL assert rsp_valid for exactly one cycle; latency accept-edge to rsp_valid = B+1 cycles.
REQ-013 On leaving XFER, if am, RA[ra] SHALL become base + B (dir=0) or base (dir=1), mod 2^RA_W; if !am, unchanged.
REQ-014 Size with B > MAX_BYTES SHALL skip XFER: no memory strobes, RA unchanged, rsp_valid with rsp_err = 1 next cycle, rsp_rdata unchanged.
REQ-015 ra_wr_en SHALL update RA[ra_wr_sel] on any edge; same-edge collision with REQ-013 update of same register: ra_wr wins.
REQ-016 In-flight transfer SHALL use latched base; RA writes during XFER do not alter its addresses.
REQ-017 req_valid outside IDLE SHALL be ignored (not queued).
REQ-018 RA and address arithmetic SHALL wrap modulo 2^RA_W (0x0000 pre-dec by 2 -> 0xFFFE).

Reset
REQ-019 While rst = 0 at an edge: state IDLE, all RA = 0, rsp_rdata = 0, rsp_valid = 0, rsp_err = 0, mem strobes/mem_rw = 0, mem_addr = 0, mem_data_out = 0, req_ready = 0 during reset, 1 from first edge after release.
REQ-020 Reset mid-transfer SHALL abort immediately: no further strobes, no RA update, no rsp_valid.

Verification
REQ-021 RA0 = 0x0080; UL store 5 am/inc; UL store 3 no-am; UL load -> MEM[80]=05, MEM[81]=03, rdata = 0x3, RA0 = 0x0081.
REQ-022 RA1 = 0x0090; word store 0x1234 am/inc -> MEM[90]=34, MEM[91]=12, RA1 = 0x0092; word load am/dec -> rdata 0x1234, RA1 = 0x0090, rsp_valid 3 cycles after accept.
REQ-023 MAX_BYTES=4: dword store 0xDEADBEEF at RA2 = 0xFFFF am/inc -> bytes EF,BE,AD,DE at RA 0xFFFF,0x0000,0x0001,0x0002 (truncated), RA2 = 0x0003.
REQ-024 MAX_BYTES=2, size 3 request -> no strobes, rsp_err = 1 one cycle after accept, RA unchanged.
REQ-025 ra_wr_en to RA1 = 0x00A0 on completion edge of am/inc byte store via RA1 -> RA1 = 0x00A0.
REQ-026 rst = 0 during second byte of word store -> only first byte written, no rsp_valid, all RA = 0, req_ready = 1 one edge after release.
